// File: rtl/march_bist_ctrl_if.sv
// Command, status and read-data bundle between the March BIST controller and its environment.
// Latency: none (wires only).
// Backpressure: none; the memory side accepts one command per cycle.
interface march_bist_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_WIDTH  = 8
);
   logic                  start;
   logic                  mem_write_read;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  busy;
   logic                  done;
   logic                  fail;
   logic [ADDR_WIDTH-1:0] fail_addr;
   logic [2:0]            fail_elem;
   logic [DATA_WIDTH-1:0] fail_data;
   logic [CNT_WIDTH-1:0]  fail_count;

   // controller side: drives memory commands and status
   modport master (
      input  start, mem_rdata,
      output mem_write_read, mem_address, mem_wdata,
      output busy, done, fail, fail_addr, fail_elem, fail_data, fail_count
   );

   // test-mode top / memory side
   modport slave (
      output start, mem_rdata,
      input  mem_write_read, mem_address, mem_wdata,
      input  busy, done, fail, fail_addr, fail_elem, fail_data, fail_count
   );
endinterface

// File: rtl/march_bist_ctrl.sv
// March C- BIST controller: six March elements over the memory, one command per cycle, first-fail capture.
// Latency: first command two cycles after start is sampled; compare two cycles after each read; done 10N+5 cycles after start.
// Backpressure: none; commands stream without stalls and start is ignored while a test is in progress.
module march_bist_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int LAST_ADDR  = 2**ADDR_WIDTH-1,
   parameter int CNT_WIDTH  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   march_bist_ctrl_if.master bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(LAST_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
   // Drain spans both command registers, both tag stages and the compare register.
   localparam logic [2:0]            DRAIN_LAST = 3'd4;

   logic [1:0]            state_q, state_d;
   logic [2:0]            elem_q, elem_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  op_q, op_d;
   logic [2:0]            drain_q, drain_d;
   logic                  clear_stat;

   logic                  two_op, down, last_op, addr_end;
   logic                  g_vld, g_wr, g_bg;
   logic [DATA_WIDTH-1:0] g_data;

   logic                  s1_vld_q, s1_wr_q;
   logic [ADDR_WIDTH-1:0] s1_addr_q;
   logic [DATA_WIDTH-1:0] s1_exp_q, wdata_q;
   logic [2:0]            s1_elem_q;

   logic                  wr2_q, rd2_q;
   logic [ADDR_WIDTH-1:0] addr2_q;
   logic [DATA_WIDTH-1:0] exp2_q;
   logic [2:0]            elem2_q;

   logic                  t1_rd_q, t2_rd_q;
   logic [DATA_WIDTH-1:0] t1_exp_q, t2_exp_q;
   logic [ADDR_WIDTH-1:0] t1_addr_q, t2_addr_q;
   logic [2:0]            t1_elem_q, t2_elem_q;

   logic                  busy_q, done_q, fail_q, miss;
   logic [ADDR_WIDTH-1:0] fail_addr_q;
   logic [2:0]            fail_elem_q;
   logic [DATA_WIDTH-1:0] fail_data_q;
   logic [CNT_WIDTH-1:0]  fail_cnt_q;

   // Generator stage G. E0 is w0 and E5 is r0; E1..E4 are read-then-write pairs.
   // Odd elements read 0 / write 1, even ones read 1 / write 0; E3/E4 walk downwards.
   assign two_op   = (elem_q != 3'd0) && (elem_q != 3'd5);
   assign down     = (elem_q == 3'd3) || (elem_q == 3'd4);
   assign g_vld    = (state_q == S_RUN);
   assign g_wr     = two_op ? op_q : (elem_q == 3'd0);
   assign g_bg     = two_op & ~(elem_q[0] ^ op_q);
   assign g_data   = {DATA_WIDTH{g_bg}};
   assign last_op  = ~two_op | op_q;
   assign addr_end = down ? (addr_q == '0) : (addr_q == LAST_A);

   // Next-state: op within element, then address, then element; end found by compare, never by wrap.
   always_comb begin
      state_d    = state_q;
      elem_d     = elem_q;
      addr_d     = addr_q;
      op_d       = op_q;
      drain_d    = drain_q;
      clear_stat = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d    = S_RUN;
               elem_d     = 3'd0;
               addr_d     = '0;
               op_d       = 1'b0;
               clear_stat = 1'b1;
            end
         end
         S_RUN: begin
            if (!last_op) begin
               op_d = 1'b1;
            end else begin
               op_d = 1'b0;
               if (!addr_end) begin
                  addr_d = down ? (addr_q - ONE_A) : (addr_q + ONE_A);
               end else if (elem_q == 3'd5) begin
                  state_d = S_DRAIN;
                  drain_d = 3'd0;
               end else begin
                  elem_d = elem_q + 3'd1;
                  addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? LAST_A : '0;
               end
            end
         end
         S_DRAIN: begin
            if (drain_q == DRAIN_LAST) state_d = S_DONE;
            else                       drain_d = drain_q + 3'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM, sequence counters and busy/done flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         elem_q  <= 3'd0;
         addr_q  <= '0;
         op_q    <= 1'b0;
         drain_q <= 3'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
         drain_q <= drain_d;
         busy_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
         done_q  <= (state_d == S_DONE);
      end
   end

   // Two command registers: write data leaves one cycle ahead of its command; address holds when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_wr_q   <= 1'b0;
         s1_addr_q <= '0;
         s1_exp_q  <= '0;
         s1_elem_q <= 3'd0;
         wdata_q   <= '0;
         wr2_q     <= 1'b0;
         rd2_q     <= 1'b0;
         addr2_q   <= '0;
         exp2_q    <= '0;
         elem2_q   <= 3'd0;
      end else begin
         s1_vld_q  <= g_vld;
         s1_wr_q   <= g_vld & g_wr;
         s1_addr_q <= addr_q;
         s1_exp_q  <= g_data;
         s1_elem_q <= elem_q;
         wdata_q   <= (g_vld && g_wr) ? g_data : '0;
         wr2_q     <= s1_vld_q & s1_wr_q;
         rd2_q     <= s1_vld_q & ~s1_wr_q;
         exp2_q    <= s1_exp_q;
         elem2_q   <= s1_elem_q;
         if (s1_vld_q) addr2_q <= s1_addr_q;
      end
   end

   // Read tags follow the memory's two-cycle read latency so the compare sees the matching data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t1_rd_q   <= 1'b0;
         t1_exp_q  <= '0;
         t1_addr_q <= '0;
         t1_elem_q <= 3'd0;
         t2_rd_q   <= 1'b0;
         t2_exp_q  <= '0;
         t2_addr_q <= '0;
         t2_elem_q <= 3'd0;
      end else begin
         t1_rd_q   <= rd2_q;
         t1_exp_q  <= exp2_q;
         t1_addr_q <= addr2_q;
         t1_elem_q <= elem2_q;
         t2_rd_q   <= t1_rd_q;
         t2_exp_q  <= t1_exp_q;
         t2_addr_q <= t1_addr_q;
         t2_elem_q <= t1_elem_q;
      end
   end

   assign miss = t2_rd_q && (bus.mem_rdata != t2_exp_q);

   // Sticky fail status: count saturates, diagnostics freeze at the first miscompare of a run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_q      <= 1'b0;
         fail_cnt_q  <= '0;
         fail_addr_q <= '0;
         fail_elem_q <= 3'd0;
         fail_data_q <= '0;
      end else if (clear_stat) begin
         fail_q      <= 1'b0;
         fail_cnt_q  <= '0;
         fail_addr_q <= '0;
         fail_elem_q <= 3'd0;
         fail_data_q <= '0;
      end else if (miss) begin
         fail_q <= 1'b1;
         if (fail_cnt_q != {CNT_WIDTH{1'b1}}) fail_cnt_q <= fail_cnt_q + CNT_WIDTH'(1);
         if (!fail_q) begin
            fail_addr_q <= t2_addr_q;
            fail_elem_q <= t2_elem_q;
            fail_data_q <= bus.mem_rdata;
         end
      end
   end

   assign bus.mem_write_read = wr2_q;
   assign bus.mem_address    = addr2_q;
   assign bus.mem_wdata      = wdata_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.fail           = fail_q;
   assign bus.fail_addr      = fail_addr_q;
   assign bus.fail_elem      = fail_elem_q;
   assign bus.fail_data      = fail_data_q;
   assign bus.fail_count     = fail_cnt_q;

endmodule
